// File: rtl/ysyx_22040127_icache_refill_axi_pkg.sv
// rtl/ysyx_22040127_icache_refill_axi_pkg.sv - shared cache line size and AXI4 read constants
package ysyx_22040127_icache_refill_axi_pkg;

    localparam int         CACHE_DATA_SIZE = 128;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [2:0] AXI_SIZE_8B     = 3'b011;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [7:0] AXI_LEN_2BEAT   = 8'd1;

endpackage

// File: rtl/ysyx_22040127_icache_refill_axi.sv
// rtl/ysyx_22040127_icache_refill_axi.sv - icache line refill over one 2-beat AXI4 INCR read burst
module ysyx_22040127_icache_refill_axi
    import ysyx_22040127_icache_refill_axi_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'd0,
    parameter int         LINE_W = CACHE_DATA_SIZE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [63:0]       req_addr,
    input  logic              req_valid,
    output logic              res_valid,
    output logic [LINE_W-1:0] res_data,
    output logic              res_err,
    output logic              busy,
    output logic [3:0]        arid,
    output logic [31:0]       araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,
    input  logic              rvalid,
    output logic              rready,
    input  logic [63:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic [3:0]        rid,
    output logic [31:0]       miss_cycles
);

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R0, S_R1, S_RESP} state_t;

    state_t            state_q;
    logic [27:0]       addr_q;
    logic [LINE_W-1:0] line_q;
    logic              err_q;
    logic [31:0]       miss_q;
    logic [31:0]       miss_d;
    logic              beat_bad;
    logic              unused_addr_bits;

    assign miss_d   = miss_q + 32'd1;
    assign beat_bad = (rresp != AXI_RESP_OKAY) || (rid != AXI_ID);
    assign unused_addr_bits = ^{req_addr[63:32], req_addr[3:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            line_q  <= '0;
            err_q   <= 1'b0;
            miss_q  <= '0;
        end else begin
            if (state_q != S_IDLE) begin
                miss_q <= miss_d;
            end
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr[31:4];
                        state_q <= S_AR;
                    end
                end
                S_AR: begin
                    if (arready) state_q <= S_R0;
                end
                S_R0: begin
                    // An early rlast ends the burst here; the upper half keeps its old contents.
                    if (rvalid) begin
                        line_q[63:0] <= rdata;
                        if (beat_bad || rlast) err_q <= 1'b1;
                        state_q <= rlast ? S_RESP : S_R1;
                    end
                end
                S_R1: begin
                    if (rvalid) begin
                        line_q[LINE_W-1:64] <= rdata;
                        if (beat_bad || !rlast) err_q <= 1'b1;
                        state_q <= S_RESP;
                    end
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign arvalid     = (state_q == S_AR);
    assign rready      = (state_q == S_R0) || (state_q == S_R1);
    assign res_valid   = (state_q == S_RESP);
    assign busy        = (state_q != S_IDLE);
    assign res_data    = line_q;
    assign res_err     = err_q;
    assign miss_cycles = miss_q;
    assign arid        = AXI_ID;
    assign araddr      = {addr_q, 4'h0};
    assign arlen       = AXI_LEN_2BEAT;
    assign arsize      = AXI_SIZE_8B;
    assign arburst     = AXI_BURST_INCR;

endmodule

// File: doc/ysyx_22040127_icache_refill_axi.md
# ysyx_22040127_icache_refill_axi

Refill bridge directly downstream of the instruction cache miss path. It takes the cache's level-held line request (16-byte aligned address), issues one AXI4 INCR read burst of two 64-bit beats, and assembles the beats into a 128-bit line. It returns the line with a one-cycle response pulse that the cache samples in its REFILL state. The block is read-only and carries one outstanding transaction.

## Interface
Parameters:
- AXI_ID, 4'd0: constant ARID; also the expected RID.
- LINE_W, `CACHE_DATA_SIZE (128): assembled line width, fixed at 2 x 64.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- req_addr  in  64  line address from cache; bits [3:0] ignored.
- req_valid  in  1  level request, held until res_valid is seen.
- res_valid  out  1  one-cycle pulse: res_data holds a complete line.
- res_data  out  LINE_W  assembled line; beat0 in [63:0], beat1 in [127:64].
- res_err  out  1  sticky: some response carried RRESP!=OKAY, RID mismatch or an RLAST violation.
- busy  out  1  high in every state other than IDLE.
- arid/araddr/arlen/arsize/arburst  out  4/32/8/3/2  set to AXI_ID, {req_addr[31:4],4'h0}, 8'd1, 3'b011, 2'b01.
- arvalid  out  1;  arready  in  1.
- rvalid  in  1;  rready  out  1;  rdata  in  64;  rresp  in  2;  rlast  in  1;  rid  in  4.
- miss_cycles  out  32  count of cycles spent with busy=1; wraps modulo 2^32.

## Operation
- States: IDLE, AR, R0, R1, RESP.
- IDLE:
  - When req_valid=1, latch req_addr[31:4] into addr_q and go to AR.
  - req_valid=0 keeps the block in IDLE.
- AR:
  - arvalid=1; araddr is driven from addr_q and stays stable.
  - On arvalid&arready go to R0.
  - req_addr changes while busy are ignored.
- R0:
  - rready=1.
  - On rvalid, write rdata into line[63:0] and go to R1.
  - If rlast=1 on this beat, set res_err and go to RESP with line[127:64] left unchanged.
- R1:
  - rready=1.
  - On rvalid, write rdata into line[127:64] and go to RESP.
  - If rlast=0 on this beat, set res_err. The block does not drain extra beats.
- Any accepted beat with rresp!=2'b00 or rid!=AXI_ID sets res_err. The beat data is still stored.
- RESP:
  - res_valid=1 for exactly one cycle, then return to IDLE unconditionally.
  - The cache clears req_valid on the same edge, so no re-issue occurs.
- res_data is valid from the res_valid cycle and holds until the next R0 beat is accepted.
- res_err is cleared only by reset.
- miss_cycles increments on every cycle in which state!=IDLE.

## Timing
- All outputs are registered. arvalid, rready and res_valid are decoded from the state register, with no input-to-output combinational paths.
- Reset values:
  - state=IDLE.
  - arvalid, rready, res_valid, busy and res_err are 0.
  - res_data=0, addr_q=0, miss_cycles=0.
- Minimum latency, with arready already high and rvalid back-to-back:
  - req_valid sampled at edge 0.
  - arvalid in cycle 1, handshake in cycle 1.
  - beats accepted in cycles 2 and 3.
  - res_valid in cycle 4.
- Each stall adds one cycle per cycle of arready=0 or rvalid=0.
- AXI rules:
  - arvalid does not drop before arready.
  - araddr, arlen, arsize and arburst are stable while arvalid=1.
  - rready=0 outside R0/R1, and rready does not depend on rvalid.
- req_valid dropping mid-transaction: the burst still completes and res_valid still pulses. The cache ignores it outside REFILL.
- Reset asserted mid-burst: return to IDLE immediately. The interconnect is reset in the same domain, so the orphaned transaction is not tracked.
- A req_valid that is high in the RESP cycle is not accepted. A new request is accepted only from IDLE.

## Structure
- Shared constants belong in the common ysyx_22040127 header, next to `CACHE_DATA_SIZE`:
  - AXI burst type INCR=2'b01.
  - size code 3'b011.
  - RESP_OKAY=2'b00.
- The state encodings are localparams local to the module.
- No sub-module: a single FSM plus one 128-bit line register and one 32-bit counter.

## Test plan
- Basic refill: req_addr=64'h8000_0123 held, arready=1, beats 64'h1111, 64'h2222 back-to-back:
  - araddr=32'h8000_0120, arlen=1, arsize=3.
  - res_valid in cycle 4 with res_data={64'h2222,64'h1111}.
  - miss_cycles=4, res_err=0.
- Backpressure: arready low for 3 cycles, then a 2-cycle rvalid gap between beats:
  - arvalid and araddr stay stable.
  - res_valid arrives 5 cycles later than baseline, at cycle 9.
  - exactly one pulse.
- Error response: beat1 rresp=2'b10:
  - the line is still delivered and res_err=1.
  - res_err stays 1 through a following clean refill.
- Protocol violations:
  - rlast=1 on beat0: RESP follows immediately and res_err=1.
  - rid=4'h3 with AXI_ID=0: res_err=1.
- Address change and reset: change req_addr during R0; then assert rst=0 in R1 of a second request:
  - the first refill uses the latched address.
  - on reset all outputs go to 0 asynchronously and the next request completes normally.
